// File: rtl/ula_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
package ula_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] SOMA          = 4'd0;
  localparam logic [OP_W-1:0] SUBTRACAO     = 4'd1;
  localparam logic [OP_W-1:0] MULTIPLICACAO = 4'd2;
  localparam logic [OP_W-1:0] DIVISAO       = 4'd3;
  localparam logic [OP_W-1:0] E             = 4'd4;
  localparam logic [OP_W-1:0] NE            = 4'd5;
  localparam logic [OP_W-1:0] OU            = 4'd6;
  localparam logic [OP_W-1:0] XOU           = 4'd7;
  localparam logic [OP_W-1:0] CMP           = 4'd8;
  localparam logic [OP_W-1:0] NAO           = 4'd9;

  typedef enum logic [1:0] {
    ESPERA      = 2'd0,
    EXECUTANDO  = 2'd1,
    SAIDA_DADOS = 2'd2
  } estado_t;

endpackage

// File: rtl/ula_core.sv
// Combinational ALU datapath: unsigned operations on A and B, results truncated to W bits.
module ula_core
  import ula_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic [W-1:0]    resultado
);

  // Division by zero saturates to all ones instead of producing X.
  function automatic logic [W-1:0] quociente_sat(input logic [W-1:0] n, input logic [W-1:0] d);
    if (d == '0) return '1;
    return n / d;
  endfunction

  always_comb begin
    resultado = '0;
    case (op)
      SOMA:          resultado = a + b;
      SUBTRACAO:     resultado = a - b;
      MULTIPLICACAO: resultado = a * b;
      DIVISAO:       resultado = quociente_sat(a, b);
      E:             resultado = a & b;
      NE:            resultado = ~(a & b);
      OU:            resultado = a | b;
      XOU:           resultado = a ^ b;
      CMP: begin
        resultado[1] = (a > b);
        resultado[0] = (a == b);
      end
      NAO:           resultado = ~a;
      default:       resultado = '0;
    endcase
  end

endmodule

// File: rtl/ula.sv
// Multi-cycle ALU wrapper: latches operands on processar, computes in one cycle, then holds the result with concluido.
module ula
  import ula_pkg::*;
#(
  parameter int Tamanho_Da_Palavra = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          processar,
  input  logic [OP_W-1:0]               op,
  input  logic [Tamanho_Da_Palavra-1:0] ETp1,
  input  logic [Tamanho_Da_Palavra-1:0] ETp2,
  output logic [Tamanho_Da_Palavra-1:0] Data,
  output logic                          concluido
);

  estado_t estadoAtual, proximoEstado;

  logic [Tamanho_Da_Palavra-1:0] temp1, temp2;
  logic [OP_W-1:0]               op_reg;
  logic [Tamanho_Da_Palavra-1:0] resultado, resultado_core;
  logic                          carregar, executar;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estadoAtual <= ESPERA;
    else        estadoAtual <= proximoEstado;
  end

  always_comb begin
    proximoEstado = ESPERA;
    case (estadoAtual)
      ESPERA:      proximoEstado = processar ? EXECUTANDO : ESPERA;
      EXECUTANDO:  proximoEstado = SAIDA_DADOS;
      SAIDA_DADOS: proximoEstado = processar ? SAIDA_DADOS : ESPERA;
      default:     proximoEstado = ESPERA;
    endcase
  end

  always_comb begin
    carregar = 1'b0;
    executar = 1'b0;
    case (estadoAtual)
      ESPERA:     carregar = processar;
      EXECUTANDO: executar = 1'b1;
      default:    ;
    endcase
  end

  ula_core #(
    .W(Tamanho_Da_Palavra)
  ) u_core (
    .a        (temp1),
    .b        (temp2),
    .op       (op_reg),
    .resultado(resultado_core)
  );

  // concluido is registered from the next state so it rises together with the new result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      temp1     <= '0;
      temp2     <= '0;
      op_reg    <= '0;
      resultado <= '0;
      concluido <= 1'b0;
    end else begin
      if (carregar) begin
        temp1  <= ETp1;
        temp2  <= ETp2;
        op_reg <= op;
      end
      if (executar) resultado <= resultado_core;
      concluido <= (proximoEstado == SAIDA_DADOS);
    end
  end

  assign Data = resultado;

endmodule

// File: tb/tb_ula.sv
// Directed plus randomized bench for ula with an arithmetic reference model.
module tb_ula;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         processar;
  logic [3:0]   op;
  logic [W-1:0] ETp1, ETp2;
  logic [W-1:0] Data;
  logic         concluido;

  int checks = 0;
  int failures = 0;

  ula #(.Tamanho_Da_Palavra(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .processar(processar),
    .op       (op),
    .ETp1     (ETp1),
    .ETp2     (ETp2),
    .Data     (Data),
    .concluido(concluido)
  );

  always #5 clk = ~clk;

  // Reference computed with plain integer arithmetic modulo 2^16.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] o);
    longint unsigned x, y, r;
    x = longint'(a);
    y = longint'(b);
    case (o)
      4'd0: r = (x + y) % 65536;
      4'd1: r = (x + 65536 - y) % 65536;
      4'd2: r = (x * y) % 65536;
      4'd3: r = (y == 0) ? 65535 : x / y;
      4'd4: r = x & y;
      4'd5: r = 65535 - (x & y);
      4'd6: r = x | y;
      4'd7: r = x ^ y;
      4'd8: r = ((x > y) ? 2 : 0) + ((x == y) ? 1 : 0);
      4'd9: r = 65535 - x;
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts an operation, scrambles the inputs after latching, holds processar for `hold` extra cycles, then releases.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] o,
                        input int hold, input string tag);
    logic [W-1:0] exp;
    exp = model(a, b, o);
    @(negedge clk);
    ETp1 = a; ETp2 = b; op = o; processar = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy"}, {15'd0, concluido}, 16'd0);
    ETp1 = W'($urandom); ETp2 = W'($urandom); op = 4'($urandom);
    @(posedge clk); #1;
    check({tag, " done"}, {15'd0, concluido}, 16'd1);
    check({tag, " data"}, Data, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, {15'd0, concluido}, 16'd1);
    end
    @(negedge clk);
    processar = 1'b0;
    @(posedge clk); #1;
    check({tag, " clear"}, {15'd0, concluido}, 16'd0);
    check({tag, " keep"}, Data, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   ro;

    reset = 1'b0; processar = 1'b0; op = '0; ETp1 = '0; ETp2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst data", Data, 16'd0);
    check("rst done", {15'd0, concluido}, 16'd0);
    check("rst state", {14'd0, dut.estadoAtual}, 16'd0);
    check("rst temp1", dut.temp1, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(16'h1234, 16'h0F0F, 4'd0, 3, "add");
    check("add const", Data, 16'h2143);
    run_op(16'h0001, 16'h0002, 4'd1, 0, "sub");
    check("sub const", Data, 16'hFFFF);
    run_op(16'h0300, 16'h0100, 4'd2, 0, "mul0");
    check("mul0 const", Data, 16'h0000);
    run_op(16'h0012, 16'h0034, 4'd2, 0, "mul1");
    check("mul1 const", Data, 16'h03A8);
    run_op(16'd100, 16'd7, 4'd3, 0, "div");
    check("div const", Data, 16'd14);
    run_op(16'd5, 16'd0, 4'd3, 0, "div0");
    check("div0 const", Data, 16'hFFFF);
    run_op(16'h0005, 16'h0005, 4'd8, 0, "cmpeq");
    check("cmpeq const", Data, 16'h0001);
    run_op(16'h0009, 16'h0003, 4'd8, 0, "cmpgt");
    check("cmpgt const", Data, 16'h0002);
    run_op(16'hF0F0, 16'hFF00, 4'd4, 0, "and");
    check("and const", Data, 16'hF000);
    run_op(16'hF0F0, 16'hFF00, 4'd5, 0, "nand");
    check("nand const", Data, 16'h0FFF);
    run_op(16'hF0F0, 16'hFF00, 4'd6, 0, "or");
    check("or const", Data, 16'hFFF0);
    run_op(16'hF0F0, 16'hFF00, 4'd7, 0, "xor");
    check("xor const", Data, 16'h0FF0);
    run_op(16'hF0F0, 16'hFF00, 4'd9, 0, "not");
    check("not const", Data, 16'h0F0F);
    run_op(16'hF0F0, 16'hFF00, 4'd12, 0, "op12");
    check("op12 const", Data, 16'h0000);

    // Reset while executing.
    @(negedge clk);
    ETp1 = 16'h1111; ETp2 = 16'h2222; op = 4'd0; processar = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0; #1;
    check("rst exec data", Data, 16'd0);
    check("rst exec done", {15'd0, concluido}, 16'd0);
    check("rst exec state", {14'd0, dut.estadoAtual}, 16'd0);
    @(negedge clk);
    processar = 1'b0; reset = 1'b1;

    // Reset while presenting the result.
    @(negedge clk);
    ETp1 = 16'h0101; ETp2 = 16'h0202; op = 4'd6; processar = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("pre rst done", {15'd0, concluido}, 16'd1);
    reset = 1'b0; #1;
    check("rst out data", Data, 16'd0);
    check("rst out done", {15'd0, concluido}, 16'd0);
    check("rst out state", {14'd0, dut.estadoAtual}, 16'd0);
    @(negedge clk);
    processar = 1'b0; reset = 1'b1;

    run_op(16'hFFFF, 16'h0001, 4'd0, 1, "add after rst");

    for (int n = 0; n < 60; n++) begin
      ra = W'($urandom);
      rb = (n % 8 == 0) ? 16'd0 : W'($urandom);
      if (n % 5 == 0) rb = ra;
      ro = 4'($urandom_range(0, 15));
      run_op(ra, rb, ro, int'($urandom_range(0, 2)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
